// File: rtl/param_parser_fifo.sv
// Synchronous FIFO with standard or first-word-fall-through read; dout registered, one-cycle read latency (FWFT: head shown 1 cycle after write).
// Writes drop with an overflow pulse when full, reads are ignored with an underflow pulse when empty; both ignored while reset recovery is busy.
module param_parser_fifo #(
  parameter int WIDTH            = 33,
  parameter int DEPTH            = 16,
  parameter int PROG_FULL_THRESH = 3,
  parameter int FWFT             = 0
) (
  input  logic                     clk,
  input  logic                     srst,
  input  logic [WIDTH-1:0]         din,
  input  logic                     wr_en,
  output logic                     full,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         dout,
  output logic                     valid,
  output logic                     empty,
  output logic                     prog_full,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     underflow,
  output logic                     wr_rst_busy,
  output logic                     rd_rst_busy
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [CW-1:0] THRESH_C = CW'(PROG_FULL_THRESH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [CW-1:0]    r_count;
  logic             r_full;
  logic             r_empty;
  logic             r_pfull;
  logic             r_valid;
  logic             r_ovf;
  logic             r_unf;
  logic [WIDTH-1:0] r_dout;
  logic [1:0]       r_busy_sr;

  logic             w_busy;
  logic             w_rd_acc;
  logic             w_wr_acc;
  logic [CW-1:0]    w_cnt_nxt;
  logic [CW-1:0]    w_remain;
  logic [AW-1:0]    w_rptr_nxt;
  logic             w_valid_nxt;
  logic [WIDTH-1:0] w_dout_nxt;

  always_comb begin
    w_busy     = r_busy_sr[1];
    w_rd_acc   = rd_en & ~r_empty & ~w_busy;
    w_wr_acc   = wr_en & ~w_busy & (~r_full | w_rd_acc);
    w_cnt_nxt  = r_count;
    if (w_wr_acc && !w_rd_acc) begin
      w_cnt_nxt = r_count + CW'(1);
    end else if (!w_wr_acc && w_rd_acc) begin
      w_cnt_nxt = r_count - CW'(1);
    end
    w_rptr_nxt = w_rd_acc ? r_rptr + AW'(1) : r_rptr;
    w_remain   = r_count - CW'(w_rd_acc);
    w_valid_nxt = w_rd_acc;
    w_dout_nxt  = r_dout;
    if (FWFT != 0) begin
      // Head after this edge: the word being written if nothing else remains, else memory at the new read pointer.
      w_valid_nxt = (w_cnt_nxt != '0);
      if (w_valid_nxt) begin
        w_dout_nxt = (w_remain == '0) ? din : r_mem[w_rptr_nxt];
      end
    end else if (w_rd_acc) begin
      w_dout_nxt = r_mem[r_rptr];
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr_acc) begin
      r_mem[r_wptr] <= din;
    end
  end

  always_ff @(posedge clk or posedge srst) begin
    if (srst) begin
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_count   <= '0;
      r_full    <= 1'b0;
      r_empty   <= 1'b1;
      r_pfull   <= 1'b0;
      r_valid   <= 1'b0;
      r_dout    <= '0;
      r_ovf     <= 1'b0;
      r_unf     <= 1'b0;
      r_busy_sr <= 2'b11;
    end else begin
      if (w_wr_acc) begin
        r_wptr <= r_wptr + AW'(1);
      end
      r_rptr    <= w_rptr_nxt;
      r_count   <= w_cnt_nxt;
      r_full    <= (w_cnt_nxt == DEPTH_C);
      r_empty   <= (w_cnt_nxt == '0);
      r_pfull   <= (w_cnt_nxt >= THRESH_C);
      r_valid   <= w_valid_nxt;
      r_dout    <= w_dout_nxt;
      r_ovf     <= wr_en & ~w_busy & r_full & ~w_rd_acc;
      r_unf     <= rd_en & ~w_busy & r_empty;
      r_busy_sr <= {r_busy_sr[0], 1'b0};
    end
  end

  assign full        = r_full;
  assign empty       = r_empty;
  assign prog_full   = r_pfull;
  assign count       = r_count;
  assign valid       = r_valid;
  assign dout        = r_dout;
  assign overflow    = r_ovf;
  assign underflow   = r_unf;
  assign wr_rst_busy = r_busy_sr[1];
  assign rd_rst_busy = r_busy_sr[1];

endmodule
